// File: rtl/board_pkg.sv
// Shared types, cell encodings and sizing helpers for the board stream link.
package board_pkg;

  localparam int unsigned CELL_W = 2;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t BLACK = 2'b01;
  localparam cell_t WHITE = 2'b10;

  function automatic int unsigned board_bits(input int unsigned n, input int unsigned cw);
    return n * n * cw;
  endfunction

  function automatic int unsigned board_beats(input int unsigned n, input int unsigned cw,
                                              input int unsigned chunk);
    return (board_bits(n, cw) + chunk - 1) / chunk;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_CKSUM = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_DATA  = 1'b0,
    RX_CKSUM = 1'b1
  } rx_state_e;

endpackage

// File: rtl/board_stream_cksum.sv
// XOR accumulator over W-bit beats; clear has priority over accumulate.
module board_stream_cksum #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         acc_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (acc_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/board_stream_link.sv
// Packed board <-> CHUNK-bit valid/ready beat stream, TX and RX fully independent.
// Define BOARD_STREAM_CKSUM_EN to append and check a per-frame XOR checksum beat.
module board_stream_link
  import board_pkg::*;
#(
  parameter int unsigned N     = 9,
  parameter int unsigned CW    = 2,
  parameter int unsigned CHUNK = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [N*N*CW-1:0]   tx_board_in,
  input  logic                tx_start_in,
  output logic                tx_busy_out,
  output logic [CHUNK-1:0]    tx_data_out,
  output logic                tx_valid_out,
  input  logic                tx_ready_in,
  input  logic [CHUNK-1:0]    rx_data_in,
  input  logic                rx_valid_in,
  output logic                rx_ready_out,
  input  logic                rx_clear_in,
  output logic [N*N*CW-1:0]   rx_board_out,
  output logic                rx_done_out,
  output logic                rx_err_out
);

  localparam int unsigned BITS    = board_bits(N, CW);
  localparam int unsigned BEATS   = board_beats(N, CW, CHUNK);
  localparam int unsigned FRAME_W = BEATS * CHUNK;
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef BOARD_STREAM_CKSUM_EN
  localparam int unsigned ASM_W   = FRAME_W;
`else
  localparam int unsigned ASM_W   = FRAME_W - CHUNK;
`endif
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [FRAME_W-1:0]   tx_shadow_q, tx_shadow_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_hs;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [ASM_W-1:0]     rx_asm_q, rx_asm_d;
  logic [BITS-1:0]      rx_board_q, rx_board_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_ready_q;
  logic                 rx_acc;

  assign tx_hs  = tx_busy_q & tx_ready_in;
  assign rx_acc = rx_valid_in & rx_ready_q;

`ifdef BOARD_STREAM_CKSUM_EN
  logic [CHUNK-1:0] tx_sum, rx_sum;
  logic             rx_err_q, rx_err_d;

  board_stream_cksum #(.W(CHUNK)) u_tx_cksum (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .clr_i   ((tx_state_q == TX_IDLE) & tx_start_in),
    .acc_i   ((tx_state_q == TX_SEND) & tx_hs),
    .data_i  (tx_shadow_q[CHUNK-1:0]),
    .sum_o   (tx_sum)
  );

  board_stream_cksum #(.W(CHUNK)) u_rx_cksum (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .clr_i   (rx_clear_in | (rx_acc & (rx_state_q == RX_CKSUM))),
    .acc_i   (rx_acc & ~rx_clear_in & (rx_state_q == RX_DATA)),
    .data_i  (rx_data_in),
    .sum_o   (rx_sum)
  );
`endif

  // TX: the shadow register shifts down one beat per handshake, so its low CHUNK bits are the beat on the wire.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_shadow_d = tx_shadow_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start_in) begin
          tx_shadow_d = FRAME_W'(tx_board_in);
          tx_cnt_d    = '0;
          tx_state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_hs) begin
          tx_cnt_d    = tx_cnt_q + CNT_W'(1);
          tx_shadow_d = tx_shadow_q >> CHUNK;
          if (tx_cnt_q == LAST_BEAT) begin
`ifdef BOARD_STREAM_CKSUM_EN
            tx_state_d                = TX_CKSUM;
            tx_shadow_d[CHUNK-1:0]    = tx_sum ^ tx_shadow_q[CHUNK-1:0];
`else
            tx_state_d                = TX_IDLE;
`endif
          end
        end
      end
      TX_CKSUM: begin
        if (tx_hs) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_busy_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_shadow_q <= '0;
      tx_busy_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_shadow_q <= tx_shadow_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // RX: beats shift in from the top; clear drops any coincident beat.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_asm_d   = rx_asm_q;
    rx_board_d = rx_board_q;
    rx_done_d  = 1'b0;
`ifdef BOARD_STREAM_CKSUM_EN
    rx_err_d   = 1'b0;
`endif
    if (rx_clear_in) begin
      rx_cnt_d   = '0;
      rx_state_d = RX_DATA;
    end else if (rx_acc) begin
      case (rx_state_q)
        RX_DATA: begin
          rx_asm_d = (rx_asm_q >> CHUNK) | (ASM_W'(rx_data_in) << (ASM_W - CHUNK));
          if (rx_cnt_q == LAST_BEAT) begin
            rx_cnt_d = '0;
`ifdef BOARD_STREAM_CKSUM_EN
            rx_state_d = RX_CKSUM;
`else
            rx_board_d = BITS'({rx_data_in, rx_asm_q});
            rx_done_d  = 1'b1;
`endif
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          rx_state_d = RX_DATA;
`ifdef BOARD_STREAM_CKSUM_EN
          if (rx_data_in == rx_sum) begin
            rx_board_d = BITS'(rx_asm_q);
            rx_done_d  = 1'b1;
          end else begin
            rx_err_d   = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_state_q <= RX_DATA;
      rx_cnt_q   <= '0;
      rx_asm_q   <= '0;
      rx_board_q <= '0;
      rx_done_q  <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_asm_q   <= rx_asm_d;
      rx_board_q <= rx_board_d;
      rx_done_q  <= rx_done_d;
      rx_ready_q <= 1'b1;
    end
  end

`ifdef BOARD_STREAM_CKSUM_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_err_q <= 1'b0;
    end else begin
      rx_err_q <= rx_err_d;
    end
  end
  assign rx_err_out = rx_err_q;
`else
  assign rx_err_out = 1'b0;
`endif

  assign tx_busy_out  = tx_busy_q;
  assign tx_valid_out = tx_busy_q;
  assign tx_data_out  = tx_shadow_q[CHUNK-1:0];
  assign rx_ready_out = rx_ready_q;
  assign rx_board_out = rx_board_q;
  assign rx_done_out  = rx_done_q;

endmodule

// File: tb/tb_board_stream_link.sv
// Scoreboard bench for board_stream_link: N=9 main instance plus an N=19 loopback instance.
module tb_board_stream_link;

  localparam int BITS   = 162;
  localparam int BEATS  = 21;
  localparam int BBITS  = 722;
  localparam int BBEATS = 91;
`ifdef BOARD_STREAM_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int FB  = BEATS + CK;
  localparam int BFB = BBEATS + CK;

  typedef struct {
    bit           err;
    logic [767:0] board;
  } rx_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BITS-1:0]   tx_board;
  logic              tx_start, tx_busy, tx_valid, tx_ready;
  logic [7:0]        tx_data, rx_data, rx_drv_data;
  logic              rx_valid, rx_drv_valid, rx_ready, rx_clear;
  logic [BITS-1:0]   rx_board;
  logic              rx_done, rx_err;
  logic              loop_en;
  logic [7:0]        flip_mask;
  int                flip_idx;
  int                cur_beat;

  logic [BBITS-1:0]  big_board, big_rx_board;
  logic              big_start, big_busy, big_valid, big_rx_ready, big_done, big_err;
  logic [7:0]        big_data;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen, done_seen, err_seen, big_seen, big_done_seen;

  logic [7:0] exp_beat[$];
  logic [7:0] big_exp_beat[$];
  rx_exp_t    exp_rx[$];
  rx_exp_t    big_exp_rx[$];
  rx_exp_t    mon_e;
  rx_exp_t    big_mon_e;

  always #5 clk = ~clk;

  assign rx_data  = loop_en ? (tx_data ^ ((cur_beat == flip_idx) ? flip_mask : 8'h00)) : rx_drv_data;
  assign rx_valid = loop_en ? (tx_valid & tx_ready) : rx_drv_valid;

  board_stream_link #(.N(9), .CW(2), .CHUNK(8)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .tx_board_in  (tx_board),
    .tx_start_in  (tx_start),
    .tx_busy_out  (tx_busy),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready),
    .rx_data_in   (rx_data),
    .rx_valid_in  (rx_valid),
    .rx_ready_out (rx_ready),
    .rx_clear_in  (rx_clear),
    .rx_board_out (rx_board),
    .rx_done_out  (rx_done),
    .rx_err_out   (rx_err)
  );

  board_stream_link #(.N(19), .CW(2), .CHUNK(8)) u_big (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .tx_board_in  (big_board),
    .tx_start_in  (big_start),
    .tx_busy_out  (big_busy),
    .tx_data_out  (big_data),
    .tx_valid_out (big_valid),
    .tx_ready_in  (1'b1),
    .rx_data_in   (big_data),
    .rx_valid_in  (big_valid),
    .rx_ready_out (big_rx_ready),
    .rx_clear_in  (1'b0),
    .rx_board_out (big_rx_board),
    .rx_done_out  (big_done),
    .rx_err_out   (big_err)
  );

  // Index of the TX beat currently on the wire, used to target link corruption.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_beat <= 0;
    else if (tx_start && !tx_busy) cur_beat <= 0;
    else if (tx_valid && tx_ready) cur_beat <= cur_beat + 1;
  end

  task automatic check(input string name, input logic [767:0] got, input logic [767:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_beat(input logic [767:0] f, input int k);
    return f[k*8 +: 8];
  endfunction

  task automatic push_tx(input logic [767:0] b, input int beats, input bit big);
    logic [7:0] x, v;
    x = 8'h00;
    for (int k = 0; k < beats; k++) begin
      v = frame_beat(b, k);
      x = x ^ v;
      if (big) big_exp_beat.push_back(v); else exp_beat.push_back(v);
    end
`ifdef BOARD_STREAM_CKSUM_EN
    if (big) big_exp_beat.push_back(x); else exp_beat.push_back(x);
`endif
  endtask

  task automatic push_rx(input bit err, input logic [767:0] b, input bit big);
    rx_exp_t e;
    e.err   = err;
    e.board = b;
    if (big) big_exp_rx.push_back(e); else exp_rx.push_back(e);
  endtask

  // Scoreboard monitors: sample mid-cycle, pop on every handshake or RX event.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (exp_beat.size() == 0) check("tx_beat_unexpected", 768'(tx_data) | 768'h100, 768'h0);
      else check("tx_beat", 768'(tx_data), 768'(exp_beat.pop_front()));
      tx_seen++;
    end
    if (rx_done || rx_err) begin
      if (rx_done) done_seen++;
      if (rx_err) err_seen++;
      if (exp_rx.size() == 0) check("rx_event_unexpected", 768'({rx_done, rx_err}), 768'h0);
      else begin
        mon_e = exp_rx.pop_front();
        check("rx_event_kind", 768'({rx_done, rx_err}), mon_e.err ? 768'h1 : 768'h2);
        if (!mon_e.err) check("rx_board", 768'(rx_board), mon_e.board);
      end
    end
    if (big_valid) begin
      if (big_seen == BBEATS - 1) check("big_last_pad", 768'(big_data[7:2]), 768'h0);
      if (big_exp_beat.size() == 0) check("big_beat_unexpected", 768'(big_data) | 768'h100, 768'h0);
      else check("big_beat", 768'(big_data), 768'(big_exp_beat.pop_front()));
      big_seen++;
    end
    if (big_done || big_err) begin
      if (big_done) big_done_seen++;
      if (big_exp_rx.size() == 0) check("big_event_unexpected", 768'({big_done, big_err}), 768'h0);
      else begin
        big_mon_e = big_exp_rx.pop_front();
        check("big_event_kind", 768'({big_done, big_err}), big_mon_e.err ? 768'h1 : 768'h2);
        check("big_board", 768'(big_rx_board), big_mon_e.board);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [767:0] b);
    tx_board = b[BITS-1:0];
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_tx_done(output int cyc);
    cyc = 0;
    while (tx_busy && cyc < 500) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_rx(input logic [767:0] b);
    logic [7:0] x, v;
    x = 8'h00;
    for (int k = 0; k < BEATS; k++) begin
      v = frame_beat(b, k);
      x = x ^ v;
      rx_drv_data  = v;
      rx_drv_valid = 1'b1;
      tick();
    end
`ifdef BOARD_STREAM_CKSUM_EN
    rx_drv_data = x;
    tick();
`endif
    rx_drv_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_busy"},  768'(tx_busy),  768'h0);
    check({tag, "_tx_valid"}, 768'(tx_valid), 768'h0);
    check({tag, "_tx_data"},  768'(tx_data),  768'h0);
    check({tag, "_rx_ready"}, 768'(rx_ready), 768'h0);
    check({tag, "_rx_board"}, 768'(rx_board), 768'h0);
    check({tag, "_rx_done"},  768'(rx_done),  768'h0);
    check({tag, "_rx_err"},   768'(rx_err),   768'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [767:0] b_a, b_b, b_c, b_d, b_e, b_f;
    int cyc, stalls;

    rst_n = 1'b0; tx_board = '0; tx_start = 1'b0; tx_ready = 1'b1;
    rx_drv_data = 8'h00; rx_drv_valid = 1'b0; rx_clear = 1'b0; loop_en = 1'b0;
    flip_mask = 8'h00; flip_idx = -1; big_board = '0; big_start = 1'b0;
    tx_seen = 0; done_seen = 0; err_seen = 0; big_seen = 0; big_done_seen = 0;

    b_a = '0; b_a[1:0] = 2'b01; b_a[161:160] = 2'b10;
    b_b = '0; b_c = '0; b_d = '0; b_e = '0; b_f = '0;
    for (int i = 0; i < 81; i++) begin
      b_b[2*i +: 2] = 2'(i % 3);
      b_c[2*i +: 2] = 2'((i + 1) % 3);
      b_d[2*i +: 2] = 2'((i * 2 + 1) % 3);
    end
    for (int i = 0; i < 361; i++) begin
      b_e[2*i +: 2] = 2'((i * 5) % 3);
      b_f[2*i +: 2] = 2'b01;
    end
    b_e[721:720] = 2'b10;

    // Reset state, then rx_ready rises on the first clock after release.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();
    check("rst_release_rx_ready", 768'(rx_ready), 768'h1);

    // Reset mid-frame: TX at beat 7, RX at beat 4.
    push_tx(b_b, BEATS, 1'b0);
    start_tx(b_b);
    for (int c = 0; c < 40; c++) begin
      if (cur_beat == 7) break;
      if (c >= 3) begin
        rx_drv_data  = 8'h50 + 8'(c);
        rx_drv_valid = 1'b1;
      end
      tick();
    end
    check("midrst_tx_beat", 768'(cur_beat), 768'd7);
    rst_n = 1'b0;
    rx_drv_valid = 1'b0;
    exp_beat.delete();
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_release_rx_ready", 768'(rx_ready), 768'h1);
    check("midrst_no_done", 768'(done_seen), 768'h0);

    // Loopback with hand-computed beats.
    loop_en = 1'b1; tx_seen = 0; done_seen = 0;
    for (int k = 0; k < BEATS; k++)
      exp_beat.push_back((k == 0) ? 8'h01 : ((k == BEATS - 1) ? 8'h02 : 8'h00));
`ifdef BOARD_STREAM_CKSUM_EN
    exp_beat.push_back(8'h03);
`endif
    push_rx(1'b0, b_a, 1'b0);
    start_tx(b_a);
    check("lb_busy_t1", 768'(tx_busy), 768'h1);
    check("lb_valid_t1", 768'(tx_valid), 768'h1);
    check("lb_first_beat", 768'(tx_data), 768'h01);
    wait_tx_done(cyc);
    check("lb_cycles", 768'(cyc), 768'(FB));
    tick(); tick();
    check("lb_beats", 768'(tx_seen), 768'(FB));
    check("lb_done_count", 768'(done_seen), 768'h1);
    check("lb_board", 768'(rx_board), b_a);

    // Backpressure: ready low for 3 cycles while beat 5 is presented.
    tx_seen = 0; done_seen = 0;
    push_tx(b_b, BEATS, 1'b0);
    push_rx(1'b0, b_b, 1'b0);
    start_tx(b_b);
    cyc = 0; stalls = 0;
    while (tx_busy && cyc < 500) begin
      if (cur_beat == 5 && stalls < 3) begin
        check("bp_hold", 768'(tx_data), 768'(frame_beat(b_b, 5)));
        tx_ready = 1'b0;
        stalls++;
      end else begin
        tx_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    check("bp_cycles", 768'(cyc), 768'(FB + 3));
    tick(); tick();
    check("bp_beats", 768'(tx_seen), 768'(FB));
    check("bp_done_count", 768'(done_seen), 768'h1);

    // Resync: partial frame, clear coinciding with a beat, then a full frame.
    loop_en = 1'b0; done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      rx_drv_data  = 8'hA0 + 8'(k);
      rx_drv_valid = 1'b1;
      tick();
    end
    rx_drv_data = 8'hFF;
    rx_clear    = 1'b1;
    tick();
    rx_clear = 1'b0;
    check("resync_board_kept", 768'(rx_board), b_b);
    push_rx(1'b0, b_c, 1'b0);
    send_rx(b_c);
    tick(); tick();
    check("resync_done_count", 768'(done_seen), 768'h1);
    check("resync_board", 768'(rx_board), b_c);

`ifdef BOARD_STREAM_CKSUM_EN
    // Corrupt bit 0 of beat 3 on the link: error pulse, board retained.
    loop_en = 1'b1; done_seen = 0; err_seen = 0;
    flip_idx = 3; flip_mask = 8'h01;
    push_tx(b_d, BEATS, 1'b0);
    push_rx(1'b1, b_c, 1'b0);
    start_tx(b_d);
    wait_tx_done(cyc);
    tick(); tick();
    flip_idx = -1; flip_mask = 8'h00;
    check("ck_err_count", 768'(err_seen), 768'h1);
    check("ck_no_done", 768'(done_seen), 768'h0);
    check("ck_board_kept", 768'(rx_board), b_c);
`endif

    // Clean frame after the previous traffic.
    loop_en = 1'b1; tx_seen = 0; done_seen = 0;
    push_tx(b_d, BEATS, 1'b0);
    push_rx(1'b0, b_d, 1'b0);
    start_tx(b_d);
    wait_tx_done(cyc);
    tick(); tick();
    check("clean_beats", 768'(tx_seen), 768'(FB));
    check("clean_done_count", 768'(done_seen), 768'h1);
    check("clean_board", 768'(rx_board), b_d);

    // N=19 round trip with a start pulse during busy that must be ignored.
    big_seen = 0; big_done_seen = 0;
    push_tx(b_e, BBEATS, 1'b1);
    push_rx(1'b0, b_e, 1'b1);
    big_board = b_e[BBITS-1:0];
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    repeat (5) tick();
    big_board = b_f[BBITS-1:0];
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    cyc = 0;
    while (big_busy && cyc < 500) begin
      tick();
      cyc++;
    end
    tick(); tick();
    check("big_idle_after", 768'(big_busy), 768'h0);
    check("big_beats", 768'(big_seen), 768'(BFB));
    check("big_done_count", 768'(big_done_seen), 768'h1);
    check("big_board_final", 768'(big_rx_board), b_e);

    check("queues_drained", 768'(exp_beat.size() + exp_rx.size() + big_exp_beat.size() + big_exp_rx.size()), 768'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_stream_link.md
# board_stream_link

Parametrised board serialiser/deserialiser. It moves an N×N board of CW-bit cells between the packed board-bus form used by the game logic and a narrow CHUNK-bit valid/ready beat stream, in both directions independently. It sits between the board-state registers and the inter-board link (transport FIFO/UART adapter), and adds an optional per-frame checksum.

## Interface
- N, default 9: board side length.
- CW, default 2: bits per cell.
- CHUNK, default 8: stream beat width.
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- tx_board_in  input  N*N*CW  board to transmit; cell (r,c) at bits [CW*(N*r+c) +: CW].
- tx_start_in  input  1  request a frame send; sampled only in TX_IDLE.
- tx_busy_out  output  1  frame in progress.
- tx_data_out  output  CHUNK  outgoing beat.
- tx_valid_out  output  1  beat valid.
- tx_ready_in  input  1  sink accepts the beat.
- rx_data_in  input  CHUNK  incoming beat.
- rx_valid_in  input  1  incoming beat valid.
- rx_ready_out  output  1  block accepts the beat.
- rx_clear_in  input  1  discard the partial frame and resync to beat 0.
- rx_board_out  output  N*N*CW  last complete received board, same cell layout.
- rx_done_out  output  1  one-cycle pulse when rx_board_out updates.
- rx_err_out  output  1  one-cycle checksum-mismatch pulse.

## Operation
- BITS = N*N*CW; BEATS = ceil(BITS/CHUNK). Beat k carries frame bits [k*CHUNK +: CHUNK], LSB first. Bits at or above BITS in the last beat are zero on TX and ignored on RX.
- TX FSM: TX_IDLE, TX_SEND, TX_CKSUM (macro only).
  - TX_IDLE with tx_start_in=1: capture tx_board_in into a shadow register, set beat count to 0, go to TX_SEND.
  - TX_SEND: tx_valid_out=1, tx_data_out = shadow beat[count]. On valid&ready, count increments. Acceptance of beat BEATS-1 goes to TX_CKSUM, or to TX_IDLE without the macro.
  - tx_start_in is ignored outside TX_IDLE. Later changes to tx_board_in do not affect the frame in flight.
  - While tx_valid_out=1 and tx_ready_in=0, tx_data_out is held stable.
- RX side:
  - rx_ready_out=1 whenever out of reset.
  - Each accepted beat is written into the assembly register at the current count, then the count increments.
  - After the final data beat (or the checksum beat, with the macro), copy the assembly register to rx_board_out, pulse rx_done_out and reset the count to 0.
  - rx_clear_in=1 resets the count to 0. If it coincides with an accepted beat, clear wins and the beat is dropped. rx_board_out is untouched.
- TX and RX are fully independent and may run simultaneously.
- Reset, any time including mid-frame: both FSMs return to idle/count 0. All outputs are 0 except rx_ready_out, which goes to 1 on the first clock after release.

## Timing
- TX: tx_start_in high at cycle t gives tx_busy_out=1 and tx_valid_out=1 from t+1.
  - With tx_ready_in held high, beats appear at t+1 … t+BEATS (t+BEATS+1 with the checksum).
  - tx_busy_out falls the cycle after the last handshake. The next tx_start_in is accepted that same cycle, so there is a 1-cycle minimum idle gap.
- RX: last beat accepted at cycle t gives rx_board_out updated and rx_done_out=1 at t+1. Zero-bubble back-to-back frames are supported.
- Throughput: one beat per cycle per direction.

## Configuration
- BOARD_STREAM_CKSUM_EN defined:
  - One extra beat follows each frame. Its value is the XOR of all BEATS data beats, padding included.
  - RX compares the received checksum with its own XOR. On match: normal update and rx_done_out pulse. On mismatch: rx_err_out pulses at t+1, rx_board_out keeps its old value, no rx_done_out.
- Not defined: no checksum beat; rx_err_out tied to 0.

## Structure
- Shared package board_pkg:
  - Cell typedef (CW-bit).
  - Cell constants EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10.
  - Functions for BITS and BEATS.
  - TX and RX state enums.
- One sub-module, board_stream_cksum: a CHUNK-bit XOR accumulator with clear and accumulate inputs, instantiated once for TX and once for RX.

## Test plan
- Reset:
  - Assert rst_n_in mid-TX (beat 7) and mid-RX (beat 4) → all outputs 0; no rx_done_out.
  - After release, rx_ready_out=1; the next full frame is received correctly.
- Loopback, N=9, CW=2, CHUNK=8:
  - Stimulus: cell (0,0)=01, cell (8,8)=10, rest 0, with tx_ready_in tied 1.
  - Required: 21 beats; beat 0 = 8'h01, beat 20 = 8'h02; rx_board_out equals tx_board_in; exactly one rx_done_out.
- Backpressure:
  - Stimulus: tx_ready_in=0 for 3 cycles while beat 5 is presented.
  - Required: tx_data_out constant throughout, no beat lost or duplicated, frame completes at cycle t+24.
- Resync:
  - Stimulus: 10 beats, then rx_clear_in together with a valid beat, then a full 21-beat frame.
  - Required: single rx_done_out; board equals the second frame.
- Checksum, macro defined:
  - Stimulus: flip bit 0 of beat 3 on the link.
  - Required: rx_err_out pulse, no rx_done_out, rx_board_out retains the previous board.
  - A clean frame then gives 22 beats and an update.
- Scaling and ignore rule:
  - Stimulus: N=19.
  - Required: 91 beats; the last beat's upper 6 bits are 0; round-trip matches.
  - A tx_start_in pulse during tx_busy_out is ignored.
